fifo_drain_scheduler: RTL

FIFO_DRAIN_SCHEDULER -- requirements
Module: fifo_drain_scheduler

---
 rtl/fifo_drain_scheduler_pkg.sv | 21 ++
 rtl/fifo_drain_scheduler_sat_counter.sv | 35 +++
 rtl/fifo_drain_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_drain_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_drain_scheduler_pkg
//  Purpose  : Shared constants for the FIFO drain scheduler: the 2-bit state
//             encoding that is also exported on the state port, and the
//             width of the dropped-sample counter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_drain_scheduler_pkg;

    localparam int c_state_w = 2;

    localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_state_w-1:0] c_st_flush = 2'd1;
    localparam logic [c_state_w-1:0] c_st_fill  = 2'd2;
    localparam logic [c_state_w-1:0] c_st_drain = 2'd3;

    localparam int c_drop_w = 16;

endpackage : fifo_drain_scheduler_pkg
`default_nettype wire

// File: rtl/fifo_drain_scheduler_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//  Ports    : clk      - rising-edge clock
//             rst      - synchronous active-high reset (count -> 0)
//             i_clr    - synchronous clear (count -> 0)
//             i_inc    - increment request
//             o_count  - current count
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fifo_drain_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_drain_scheduler
//  Purpose  : Sequences a capture FIFO through FLUSH (discard stale words),
//             FILL (write one word per sample_tick until full) and DRAIN
//             (hand words to the CPU one at a time with a ready handshake).
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             sample_tick        - one strobe per new sample
//             arm / abort        - start a capture / cancel everything
//             continuous         - 1: refill after each drain, 0: go idle
//             fifo_wrfull/rdempty, fifo_wrreq/rdreq - FIFO handshake
//             out_valid/out_ready - word hand-off to the CPU
//             busy, done, state  - status; done pulses on drain completion
//             word_count         - words handed off in the current drain
//             drop_count         - saturating count of samples lost
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_drain_scheduler
    import fifo_drain_scheduler_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                arm,
    input  logic                continuous,
    input  logic                abort,
    input  logic                fifo_wrfull,
    input  logic                fifo_rdempty,
    output logic                fifo_wrreq,
    output logic                fifo_rdreq,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    word_count,
    output logic [c_drop_w-1:0] drop_count,
    output logic [c_state_w-1:0] state
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_pending;
    logic                 r_out_valid;
    logic [CNT_W-1:0]     r_word_count;

    logic                 w_idle;
    logic                 w_flush;
    logic                 w_fill;
    logic                 w_drain;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_wc_acc;
    logic                 w_valid_after;
    logic                 w_drain_rd;
    logic                 w_drain_done;
    logic                 w_arm_go;

    assign w_idle  = (r_state == c_st_idle);
    assign w_flush = (r_state == c_st_flush);
    assign w_fill  = (r_state == c_st_fill);
    assign w_drain = (r_state == c_st_drain);

    // The accept on this edge is folded in before completion is judged, so a
    // last-word accept and the completion land on the same cycle.
    assign w_accept      = w_drain && r_out_valid && out_ready;
    assign w_wc_acc      = r_word_count + {{(CNT_W-1){1'b0}}, w_accept};
    assign w_valid_after = r_out_valid && !w_accept;

    // One word in flight at most: no new read while one is pending or shown.
    assign w_drain_rd   = w_drain && !fifo_rdempty && !r_pending && !r_out_valid;
    assign w_drain_done = w_drain &&
                          ((w_wc_acc >= c_depth) ||
                           (fifo_rdempty && !r_pending && !w_valid_after));

    assign w_arm_go = w_idle && arm && !abort;

    assign fifo_wrreq = !reset && !abort && w_fill && sample_tick && !fifo_wrfull;
    assign fifo_rdreq = !reset && !abort &&
                        ((w_flush && !fifo_rdempty) || w_drain_rd);
    assign done       = !reset && !abort && w_drain_done;

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (arm)          w_state_nxt = c_st_flush;
                c_st_flush: if (fifo_rdempty) w_state_nxt = c_st_fill;
                c_st_fill:  if (fifo_wrfull)  w_state_nxt = c_st_drain;
                c_st_drain: if (w_drain_done)
                                w_state_nxt = continuous ? c_st_fill : c_st_idle;
                default:    w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_pending    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (abort) begin
                r_pending   <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_pending <= w_drain_rd;
                // FIFO q is valid the cycle after rdreq; it is presented on
                // the edge closing that cycle.
                if (r_pending) begin
                    r_out_valid <= 1'b1;
                end else if (w_accept) begin
                    r_out_valid <= 1'b0;
                end
                if (w_arm_go || (w_fill && fifo_wrfull)) begin
                    r_word_count <= '0;
                end else if (w_accept) begin
                    r_word_count <= w_wc_acc;
                end
            end
        end
    end

    // Samples arriving while the FIFO is not being written are lost.
    sat_counter #(
        .WIDTH (c_drop_w)
    ) u_drop_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_arm_go),
        .i_inc   (sample_tick && (w_flush || w_drain)),
        .o_count (drop_count)
    );

    assign out_valid  = r_out_valid;
    assign word_count = r_word_count;
    assign state      = r_state;
    assign busy       = !w_idle;

endmodule : fifo_drain_scheduler
`default_nettype wire
